// File: rtl/uart_pkg.sv
// Shared UART timing constants and the tx-queue pacing state type.
// Used by uart_txq_fifo and uart_tx_queue (optional overflow flag: UART_TXQ_OVF_EN).
package uart_pkg;

    localparam int CLK_PER_HALF_CYCLE = 542;
    localparam int UART_BIT_CLKS      = 2 * (CLK_PER_HALF_CYCLE + 1);

    // Ready pulse: one bit time rounded up to the next 200 clocks, so the transmitter sees it exactly once
    localparam int TXQ_RDY_CLKS       = ((UART_BIT_CLKS / 200) + 1) * 200;
    // Frame pacing: start + 8 data + stop plus two bits of idle line
    localparam int TXQ_FRAME_CLKS     = 12 * UART_BIT_CLKS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } txq_state_e;

endpackage

// File: rtl/uart_txq_fifo.sv
// Synchronous byte FIFO feeding the UART pacer; full, empty and count are registered.
// Writes are accepted only while the registered full flag is low.
module uart_txq_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_125MHz,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_d,
    input  logic                   pop,
    output logic [7:0]             head_d,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [CW-1:0] count_nxt_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head_d    = mem_r[rd_ptr_r];

    // Next occupancy: a simultaneous push and pop cancel out
    always_comb begin
        count_nxt_s = count;
        if (push_ok_s && !pop_ok_s) begin
            count_nxt_s = count + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_nxt_s = count - CW'(1);
        end else begin
            count_nxt_s = count;
        end
    end

    // Byte storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk_125MHz) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_d;
        end
    end

    // Pointers (wrap naturally at the power-of-two depth) and status flags
    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count    <= {CW{1'b0}};
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count <= count_nxt_s;
            full  <= (count_nxt_s == CW'(DEPTH));
            empty <= (count_nxt_s == {CW{1'b0}});
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus open-loop frame pacer in front of a UART transmitter without busy/ack.
// Define UART_TXQ_OVF_EN to add the sticky overflow flag and its ovf_clr input.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RDY_CLKS   = TXQ_RDY_CLKS,
    parameter int FRAME_CLKS = TXQ_FRAME_CLKS
) (
    input  logic                   clk_125MHz,
    input  logic                   rst,
    input  logic [7:0]             wr_d,
    input  logic                   wr_en,
`ifdef UART_TXQ_OVF_EN
    input  logic                   ovf_clr,
    output logic                   overflow,
`endif
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             tx_d,
    output logic                   tx_rdy
);

    localparam int TW = $clog2(FRAME_CLKS);

    txq_state_e    state_r;
    logic [TW-1:0] cnt_r;
    logic [7:0]    head_d_s;
    logic          pop_s;

    assign pop_s = (state_r == IDLE) && !empty;

    uart_txq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_125MHz (clk_125MHz),
        .rst        (rst),
        .push       (wr_en),
        .push_d     (wr_d),
        .pop        (pop_s),
        .head_d     (head_d_s),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Pacing FSM: one IDLE cycle, RDY_CLKS of tx_rdy, then hold tx_d until the frame time elapses
    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {TW{1'b0}};
            tx_d    <= 8'h00;
            tx_rdy  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!empty) begin
                        tx_d    <= head_d_s;
                        cnt_r   <= {TW{1'b0}};
                        tx_rdy  <= 1'b1;
                        state_r <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_r <= cnt_r + TW'(1);
                    if (cnt_r == TW'(RDY_CLKS - 1)) begin
                        tx_rdy  <= 1'b0;
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    // Counter stops at its terminal value so it never wraps
                    if (cnt_r == TW'(FRAME_CLKS - 1)) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + TW'(1);
                    end
                end
                default: begin
                    tx_rdy  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    // Sticky drop flag; a new drop wins over a coincident clear
    always_ff @(posedge clk_125MHz or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a small-parameter DUT against a queue/timing model,
// and a default-parameter DUT driving a behavioural UART transmitter and receiver.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int RDY   = 4;
    localparam int FRAME = 20;
    localparam int CW    = 5;

    logic          clk_125MHz = 1'b0;
    logic          rst        = 1'b1;
    logic [7:0]    wr_d       = 8'h00;
    logic          wr_en      = 1'b0;
    logic          full, empty, tx_rdy;
    logic [CW-1:0] count;
    logic [7:0]    tx_d;
    logic [7:0]    wr_d2      = 8'h00;
    logic          wr_en2     = 1'b0;
    logic          full2, empty2, tx_rdy2;
    logic [CW-1:0] count2;
    logic [7:0]    tx_d2;
`ifdef UART_TXQ_OVF_EN
    logic          ovf_clr    = 1'b0;
    logic          ovf_clr2   = 1'b0;
    logic          overflow, overflow2;
`endif

    int tests = 0;
    int fails = 0;

    always #4 clk_125MHz = ~clk_125MHz;

    uart_tx_queue #(.DEPTH(DEPTH), .RDY_CLKS(RDY), .FRAME_CLKS(FRAME)) dut (
        .clk_125MHz (clk_125MHz), .rst (rst), .wr_d (wr_d), .wr_en (wr_en),
`ifdef UART_TXQ_OVF_EN
        .ovf_clr (ovf_clr), .overflow (overflow),
`endif
        .full (full), .empty (empty), .count (count), .tx_d (tx_d), .tx_rdy (tx_rdy)
    );

    uart_tx_queue dut2 (
        .clk_125MHz (clk_125MHz), .rst (rst), .wr_d (wr_d2), .wr_en (wr_en2),
`ifdef UART_TXQ_OVF_EN
        .ovf_clr (ovf_clr2), .overflow (overflow2),
`endif
        .full (full2), .empty (empty2), .count (count2), .tx_d (tx_d2), .tx_rdy (tx_rdy2)
    );

    // Reference model: byte queue plus "earliest next launch" time
    byte unsigned mq[$];
    int           cyc       = 0;
    int           m_next_ok = 0;
    int           m_launch  = -1;
    logic [7:0]   m_tx_d    = 8'h00;
    logic         m_ovf     = 1'b0;

    initial forever begin : model
        int occ;
        @(posedge clk_125MHz or posedge rst);
        if (rst) begin
            mq.delete();
            m_next_ok = 0;
            m_launch  = -1;
            m_tx_d    = 8'h00;
            m_ovf     = 1'b0;
        end else begin
            cyc++;
            occ = mq.size();
            if (occ > 0 && cyc >= m_next_ok) begin
                m_tx_d    = mq.pop_front();
                m_launch  = cyc;
                m_next_ok = cyc + FRAME + 1;
            end
            if (wr_en && occ < DEPTH) mq.push_back(wr_d);
            if (wr_en && occ == DEPTH) m_ovf = 1'b1;
`ifdef UART_TXQ_OVF_EN
            else if (ovf_clr) m_ovf = 1'b0;
`endif
        end
    end

    logic [CW+10:0] obs_vec;
    assign obs_vec = {count, empty, full, tx_rdy, tx_d};

    function automatic logic [CW+10:0] exp_vec();
        logic r;
        r = (m_launch >= 0) && (cyc - m_launch < RDY);
        return {CW'(mq.size()), (mq.size() == 0), (mq.size() == DEPTH), r, m_tx_d};
    endfunction

    // Behavioural UART transmitter on dut2: checks tx_rdy once per bit tick when idle
    logic line = 1'b1;
    initial begin : uart_tx_model
        logic [9:0] frame;
        int nbits;
        nbits = 0;
        frame = 10'h3ff;
        forever begin
            repeat (UART_BIT_CLKS) @(posedge clk_125MHz);
            if (nbits == 0 && tx_rdy2) begin
                frame = {1'b1, tx_d2, 1'b0};
                nbits = 10;
            end
            if (nbits != 0) begin
                line  = frame[0];
                frame = frame >> 1;
                nbits--;
            end
        end
    end

    // Behavioural receiver decoding the serial line at mid-bit
    byte unsigned rx_q[$];
    int           frame_err = 0;
    initial begin : uart_rx_model
        logic [7:0] b;
        forever begin
            @(negedge line);
            repeat (UART_BIT_CLKS / 2) @(posedge clk_125MHz);
            if (line == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (UART_BIT_CLKS) @(posedge clk_125MHz);
                    b[i] = line;
                end
                repeat (UART_BIT_CLKS) @(posedge clk_125MHz);
                if (line != 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        wr_en  = 1'b0;
        wr_en2 = 1'b0;
        repeat (2) @(negedge clk_125MHz);
        rst = 1'b0;
        @(negedge clk_125MHz);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obs_vec !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, {5'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
`ifdef UART_TXQ_OVF_EN
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_overflow: got %b expected 0", overflow);
        end
`endif
    endtask

    task automatic test_single();
        int hi;
        wr_d  = 8'h55;
        wr_en = 1'b1;
        @(negedge clk_125MHz);
        wr_en = 1'b0;
        tests++;
        if ({count, empty, tx_rdy} !== {5'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_after_write: got cnt=%0d empty=%b rdy=%b expected 1 0 0", count, empty, tx_rdy);
        end
        @(negedge clk_125MHz);
        tests++;
        if ({tx_d, tx_rdy, empty, count} !== {8'h55, 1'b1, 1'b1, 5'd0}) begin
            fails++;
            $display("FAIL single_launch: got tx_d=%h rdy=%b empty=%b cnt=%0d expected 55 1 1 0", tx_d, tx_rdy, empty, count);
        end
        hi = 1;
        for (int k = 0; k < FRAME + 4; k++) begin
            @(negedge clk_125MHz);
            if (tx_rdy) hi++;
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++;
                $display("FAIL single_model cyc=%0d: got %h expected %h", cyc, obs_vec, exp_vec());
            end
        end
        tests++;
        if (hi !== RDY) begin
            fails++;
            $display("FAIL single_rdy_width: got %0d expected %0d", hi, RDY);
        end
    endtask

    task automatic test_burst(input byte unsigned b[$], input string name);
        int   rises[$];
        byte unsigned rd[$];
        int   n0, peak, exp_peak, len, w, p;
        logic prev;
        len  = b.size();
        peak = 0;
        prev = 1'b0;
        n0   = 0;
        for (int k = 0; k < len * (FRAME + 1) + FRAME; k++) begin
            if (k > 0) begin
                tests++;
                if (obs_vec !== exp_vec()) begin
                    fails++;
                    $display("FAIL %s_model cyc=%0d: got %h expected %h", name, cyc, obs_vec, exp_vec());
                end
                if (int'(count) > peak) peak = int'(count);
                if (tx_rdy && !prev) begin
                    rises.push_back(cyc);
                    rd.push_back(tx_d);
                end
                prev = tx_rdy;
            end
            if (k < len) begin
                wr_en = 1'b1;
                wr_d  = b[k];
            end else begin
                wr_en = 1'b0;
            end
            if (k == 0) n0 = cyc + 1;
            @(negedge clk_125MHz);
        end
        // Occupancy after edge n0+t: writes so far minus launches so far
        exp_peak = 0;
        for (int t = 0; t <= len; t++) begin
            w = (t + 1 < len) ? t + 1 : len;
            p = (t >= 1) ? ((t - 1) / (FRAME + 1) + 1) : 0;
            if (w - p > exp_peak) exp_peak = w - p;
        end
        tests++;
        if (peak !== exp_peak) begin
            fails++;
            $display("FAIL %s_peak: got %0d expected %0d", name, peak, exp_peak);
        end
        tests++;
        if (rises.size() !== len) begin
            fails++;
            $display("FAIL %s_launches: got %0d expected %0d", name, rises.size(), len);
        end
        for (int i = 0; i < len && i < rises.size(); i++) begin
            tests++;
            if (rises[i] !== n0 + 1 + (FRAME + 1) * i || rd[i] !== b[i]) begin
                fails++;
                $display("FAIL %s_rise%0d: got cyc=%0d byte=%h expected cyc=%0d byte=%h",
                         name, i, rises[i], rd[i], n0 + 1 + (FRAME + 1) * i, b[i]);
            end
        end
        tests++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            fails++;
            $display("FAIL %s_drained: got cnt=%0d empty=%b expected 0 1", name, count, empty);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wr_d  = 8'($urandom);
        wr_en = 1'b1;
        @(negedge clk_125MHz);
        wr_en = 1'b0;
        @(negedge clk_125MHz);
        for (int k = 0; k < DEPTH + 1; k++) begin
            wr_en = 1'b1;
            wr_d  = 8'($urandom);
            @(negedge clk_125MHz);
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++;
                $display("FAIL ovf_fill cyc=%0d: got %h expected %h", cyc, obs_vec, exp_vec());
            end
        end
        wr_en = 1'b0;
        tests++;
        if ({full, count} !== {1'b1, 5'd16}) begin
            fails++;
            $display("FAIL ovf_full: got full=%b cnt=%0d expected 1 16", full, count);
        end
`ifdef UART_TXQ_OVF_EN
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got %b expected 1", overflow);
        end
        @(negedge clk_125MHz);
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk_125MHz);
        ovf_clr = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
`else
        repeat (2) @(negedge clk_125MHz);
`endif
        // Line up a write with the pop edge while the queue is still full
        for (int g = 0; g < 4 * FRAME && cyc + 1 != m_next_ok; g++) @(negedge clk_125MHz);
        tests++;
        if (count !== 5'd16) begin
            fails++;
            $display("FAIL ovf_pre_pop: got cnt=%0d expected 16", count);
        end
        wr_en = 1'b1;
        wr_d  = 8'hEE;
        @(negedge clk_125MHz);
        wr_en = 1'b0;
        tests++;
        if ({full, count} !== {1'b0, 5'd15}) begin
            fails++;
            $display("FAIL ovf_pop_drop: got full=%b cnt=%0d expected 0 15", full, count);
        end
`ifdef UART_TXQ_OVF_EN
        tests++;
        if (overflow !== m_ovf) begin
            fails++;
            $display("FAIL ovf_pop_flag: got %b expected %b", overflow, m_ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk_125MHz);
        ovf_clr = 1'b0;
`endif
        for (int k = 0; k < DEPTH * (FRAME + 1) + 4; k++) begin
            @(negedge clk_125MHz);
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++;
                $display("FAIL ovf_drain cyc=%0d: got %h expected %h", cyc, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1;
            wr_d  = 8'($urandom);
            @(negedge clk_125MHz);
        end
        wr_en = 1'b0;
        tests++;
        if ({count, tx_rdy} !== {5'd3, 1'b1}) begin
            fails++;
            $display("FAIL midrst_setup: got cnt=%0d rdy=%b expected 3 1", count, tx_rdy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (obs_vec !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00} || obs_vec !== exp_vec()) begin
            fails++;
            $display("FAIL midrst_async: got %h expected %h", obs_vec, {5'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        @(negedge clk_125MHz);
        rst = 1'b0;
        @(negedge clk_125MHz);
        wr_d  = 8'hA5;
        wr_en = 1'b1;
        @(negedge clk_125MHz);
        wr_en = 1'b0;
        @(negedge clk_125MHz);
        tests++;
        if ({tx_d, tx_rdy} !== {8'hA5, 1'b1}) begin
            fails++;
            $display("FAIL midrst_relaunch: got tx_d=%h rdy=%b expected a5 1", tx_d, tx_rdy);
        end
        for (int k = 0; k < FRAME + 2; k++) begin
            @(negedge clk_125MHz);
            tests++;
            if (obs_vec !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_model cyc=%0d: got %h expected %h", cyc, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_uart();
        rx_q.delete();
        wr_d2  = 8'h48;
        wr_en2 = 1'b1;
        @(negedge clk_125MHz);
        wr_d2  = 8'h69;
        @(negedge clk_125MHz);
        wr_en2 = 1'b0;
        for (int g = 0; g < 40000 && rx_q.size() < 2; g++) @(negedge clk_125MHz);
        repeat (14000) @(negedge clk_125MHz);
        tests++;
        if (rx_q.size() !== 2) begin
            fails++;
            $display("FAIL uart_frames: got %0d frames expected 2", rx_q.size());
        end
        tests++;
        if (rx_q.size() < 2 || rx_q[0] !== 8'h48 || rx_q[1] !== 8'h69) begin
            fails++;
            $display("FAIL uart_bytes: got %p expected 48 69", rx_q);
        end
        tests++;
        if (frame_err !== 0 || {count2, tx_rdy2} !== {5'd0, 1'b0}) begin
            fails++;
            $display("FAIL uart_clean: got frame_err=%0d cnt=%0d rdy=%b expected 0 0 0", frame_err, count2, tx_rdy2);
        end
    endtask

    initial begin
        byte unsigned bq[$];
        int n;
        test_reset();
        test_single();
        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        test_burst(bq, "burst_fixed");
        repeat (2) begin
            bq.delete();
            n = $urandom_range(2, 8);
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            test_burst(bq, "burst_rand");
        end
        test_overflow();
        test_reset_mid();
        test_uart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
